// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
// Module  : combat_resolver
// Purpose : per-tank life FSMs, kill/block scoring and round outcome for
//           NUM_PLAYERS players and NUM_ENEMIES enemies. Optional spawn
//           shield enabled by defining COMBAT_SHIELD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module combat_resolver #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_ENEMIES   = 4,
  parameter int LIVES_W       = 4,
  parameter int SCORE_W       = 11,
  parameter int REVIVE_CYCLES = 1000000,
  parameter int SHIELD_CYCLES = 250000,
  parameter int KILL_POINTS   = 10,
  parameter int BLOCK_POINTS  = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               round_start_i,
  input  logic                               score_clear_i,
  input  logic [NUM_PLAYERS*LIVES_W-1:0]     player_lives_i,
  input  logic [NUM_ENEMIES*LIVES_W-1:0]     enemy_lives_i,
  input  logic [NUM_PLAYERS-1:0]             player_box_i,
  input  logic [NUM_PLAYERS-1:0]             player_bullet_i,
  input  logic [NUM_ENEMIES-1:0]             enemy_box_i,
  input  logic [NUM_ENEMIES-1:0]             enemy_bullet_i,
  input  logic                               hard_block_i,
  input  logic                               destroyable_block_i,
  input  logic                               eagle_block_i,
  output logic [NUM_PLAYERS-1:0]             player_bullet_explode_o,
  output logic [NUM_ENEMIES-1:0]             enemy_bullet_explode_o,
  output logic                               bullet_collide_wall_o,
  output logic                               bullet_collide_eagle_o,
  output logic [NUM_PLAYERS-1:0]             player_die_o,
  output logic [NUM_ENEMIES-1:0]             enemy_die_o,
  output logic [NUM_PLAYERS-1:0]             player_revive_o,
  output logic [NUM_ENEMIES-1:0]             enemy_revive_o,
  output logic [NUM_PLAYERS-1:0]             player_alive_o,
  output logic [NUM_ENEMIES-1:0]             enemy_alive_o,
  output logic [NUM_PLAYERS*LIVES_W-1:0]     player_lives_left_o,
  output logic [$clog2(NUM_ENEMIES+1)-1:0]   enemies_active_o,
  output logic [NUM_PLAYERS*SCORE_W-1:0]     player_score_o,
  output logic                               game_over_o,
  output logic                               victory_o
);

  localparam int NUM_T = NUM_PLAYERS + NUM_ENEMIES;
  localparam int ACT_W = $clog2(NUM_ENEMIES + 1);
`ifdef COMBAT_SHIELD_EN
  localparam int CNT_MAX = (REVIVE_CYCLES > SHIELD_CYCLES) ? REVIVE_CYCLES : SHIELD_CYCLES;
`else
  localparam int CNT_MAX = REVIVE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LIVING = 3'd1,
    ST_HIT    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SHIELD = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  if (REVIVE_CYCLES < 2 || SHIELD_CYCLES < 1) begin : g_param_check
    $error("combat_resolver: REVIVE_CYCLES must be >= 2 and SHIELD_CYCLES >= 1");
  end

  logic w_any_pbox, w_any_ebox, w_any_pbul, w_any_ebul, w_any_bul;

  assign w_any_pbox = |player_box_i;
  assign w_any_ebox = |enemy_box_i;
  assign w_any_pbul = |player_bullet_i;
  assign w_any_ebul = |enemy_bullet_i;
  assign w_any_bul  = w_any_pbul | w_any_ebul;

  assign player_bullet_explode_o = player_bullet_i &
      {NUM_PLAYERS{hard_block_i | w_any_pbox | w_any_ebox | w_any_ebul}};
  assign enemy_bullet_explode_o  = enemy_bullet_i &
      {NUM_ENEMIES{hard_block_i | w_any_pbox | w_any_ebox | w_any_pbul}};
  assign bullet_collide_wall_o   = destroyable_block_i & w_any_bul;
  assign bullet_collide_eagle_o  = eagle_block_i & w_any_bul;

  // Tanks 0..NUM_PLAYERS-1 are players, the rest enemies.
  logic [NUM_T-1:0]         w_hit, w_alive, w_die, w_revive, w_out_d;
  logic [NUM_ENEMIES-1:0]   w_kill, w_active_d;
  logic [NUM_T*LIVES_W-1:0] w_lives_init;

  assign w_lives_init = {enemy_lives_i, player_lives_i};
  assign w_hit = {enemy_box_i & {NUM_ENEMIES{w_any_pbul}},
                  player_box_i & {NUM_PLAYERS{w_any_ebul}}};

  genvar t;
  for (t = 0; t < NUM_T; t++) begin : g_tank
    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d, lives_init;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               die_q, die_d, revive_q, revive_d;

    assign lives_init = w_lives_init[t*LIVES_W +: LIVES_W];

    always_comb begin
      state_d  = state_q;
      lives_d  = lives_q;
      cnt_d    = cnt_q;
      die_d    = 1'b0;
      revive_d = 1'b0;
      if (round_start_i) begin
        lives_d = lives_init;
        cnt_d   = '0;
        state_d = (lives_init != '0) ? ST_LIVING : ST_OUT;
      end else begin
        case (state_q)
          ST_LIVING: begin
            if (w_hit[t]) begin
              state_d = ST_HIT;
              die_d   = 1'b1;
            end
          end
          ST_HIT: begin
            lives_d = lives_q - LIVES_W'(1);
            cnt_d   = '0;
            state_d = (lives_q > LIVES_W'(1)) ? ST_WAIT : ST_OUT;
          end
          ST_WAIT: begin
            if (cnt_q == CNT_W'(REVIVE_CYCLES - 1)) begin
              cnt_d    = '0;
              revive_d = 1'b1;
`ifdef COMBAT_SHIELD_EN
              state_d  = ST_SHIELD;
`else
              state_d  = ST_LIVING;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef COMBAT_SHIELD_EN
          ST_SHIELD: begin
            if (cnt_q == CNT_W'(SHIELD_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = ST_LIVING;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state_q  <= ST_IDLE;
        lives_q  <= '0;
        cnt_q    <= '0;
        die_q    <= 1'b0;
        revive_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        lives_q  <= lives_d;
        cnt_q    <= cnt_d;
        die_q    <= die_d;
        revive_q <= revive_d;
      end
    end

    assign w_alive[t]  = (state_q == ST_LIVING) || (state_q == ST_SHIELD);
    assign w_die[t]    = die_q;
    assign w_revive[t] = revive_q;
    assign w_out_d[t]  = (state_d == ST_OUT);

    if (t >= NUM_PLAYERS) begin : g_enemy
      // An enemy LIVING->HIT transition is exactly one kill event.
      assign w_kill[t-NUM_PLAYERS]     = die_d;
      assign w_active_d[t-NUM_PLAYERS] = (state_d != ST_IDLE) && (state_d != ST_OUT);
    end else begin : g_player
      assign player_lives_left_o[t*LIVES_W +: LIVES_W] = lives_q;
    end
  end

  assign player_alive_o  = w_alive[NUM_PLAYERS-1:0];
  assign enemy_alive_o   = w_alive[NUM_T-1:NUM_PLAYERS];
  assign player_die_o    = w_die[NUM_PLAYERS-1:0];
  assign enemy_die_o     = w_die[NUM_T-1:NUM_PLAYERS];
  assign player_revive_o = w_revive[NUM_PLAYERS-1:0];
  assign enemy_revive_o  = w_revive[NUM_T-1:NUM_PLAYERS];

  genvar p;
  for (p = 0; p < NUM_PLAYERS; p++) begin : g_score
    logic [SCORE_W-1:0] score_q, score_d;
    logic               blk_q, w_blk, w_rise;
    logic [31:0]        w_kills, w_sum;

    assign w_blk  = player_bullet_i[p] & destroyable_block_i;
    assign w_rise = w_blk & ~blk_q;

    always_comb begin
      w_kills = '0;
      for (int e = 0; e < NUM_ENEMIES; e++) begin
        w_kills = w_kills + 32'(w_kill[e]);
      end
      w_sum = 32'(score_q)
            + (player_bullet_i[p] ? w_kills * 32'(KILL_POINTS) : 32'd0)
            + (w_rise ? 32'(BLOCK_POINTS) : 32'd0);
      if (score_clear_i) begin
        score_d = '0;
      end else if (w_sum > 32'(SCORE_MAX)) begin
        score_d = SCORE_MAX;
      end else begin
        score_d = w_sum[SCORE_W-1:0];
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        score_q <= '0;
        blk_q   <= 1'b0;
      end else begin
        score_q <= score_d;
        blk_q   <= w_blk;
      end
    end

    assign player_score_o[p*SCORE_W +: SCORE_W] = score_q;
  end

  logic             game_over_q, game_over_d, victory_q, victory_d;
  logic [ACT_W-1:0] active_q, active_d;

  // Outcome flags and the active count follow next-state so they line up
  // with the tank states in the same cycle.
  always_comb begin
    active_d = '0;
    for (int e = 0; e < NUM_ENEMIES; e++) begin
      active_d = active_d + ACT_W'(w_active_d[e]);
    end
    game_over_d = (game_over_q & ~round_start_i)
                | (&w_out_d[NUM_PLAYERS-1:0])
                | (bullet_collide_eagle_o & ~round_start_i);
    victory_d   = (victory_q & ~round_start_i)
                | ((&w_out_d[NUM_T-1:NUM_PLAYERS]) & ~game_over_d);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      game_over_q <= 1'b0;
      victory_q   <= 1'b0;
      active_q    <= '0;
    end else begin
      game_over_q <= game_over_d;
      victory_q   <= victory_d;
      active_q    <= active_d;
    end
  end

  assign game_over_o      = game_over_q;
  assign victory_o        = victory_q;
  assign enemies_active_o = active_q;

endmodule
`default_nettype wire

// File: tb/tb_combat_resolver.sv
`default_nettype none
// ============================================================================
// Module  : tb_combat_resolver
// Purpose : directed + randomized bench for combat_resolver with a
//           behavioural model compared every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_combat_resolver;
  localparam int NP = 2, NE = 4, LW = 4, SW = 11, RC = 6, SC = 4, KP = 10, BP = 1;
  localparam int NT = NP + NE;
  localparam int AW = $clog2(NE + 1);
  localparam int SMAX = (1 << SW) - 1;
  localparam int M_IDLE = 0, M_LIV = 1, M_HIT = 2, M_WAIT = 3, M_SHLD = 4, M_OUT = 5;

  logic clk = 1'b0, reset_ni = 1'b0, round_start_i = 1'b0, score_clear_i = 1'b0;
  logic [NP*LW-1:0] player_lives_i = '0;
  logic [NE*LW-1:0] enemy_lives_i = '0;
  logic [NP-1:0] player_box_i = '0, player_bullet_i = '0;
  logic [NE-1:0] enemy_box_i = '0, enemy_bullet_i = '0;
  logic hard_block_i = 1'b0, destroyable_block_i = 1'b0, eagle_block_i = 1'b0;
  logic [NP-1:0] player_bullet_explode_o, player_die_o, player_revive_o, player_alive_o;
  logic [NE-1:0] enemy_bullet_explode_o, enemy_die_o, enemy_revive_o, enemy_alive_o;
  logic bullet_collide_wall_o, bullet_collide_eagle_o, game_over_o, victory_o;
  logic [NP*LW-1:0] player_lives_left_o;
  logic [AW-1:0] enemies_active_o;
  logic [NP*SW-1:0] player_score_o;

  always #5 clk = ~clk;

  combat_resolver #(
    .NUM_PLAYERS(NP), .NUM_ENEMIES(NE), .LIVES_W(LW), .SCORE_W(SW),
    .REVIVE_CYCLES(RC), .SHIELD_CYCLES(SC), .KILL_POINTS(KP), .BLOCK_POINTS(BP)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .round_start_i(round_start_i),
    .score_clear_i(score_clear_i), .player_lives_i(player_lives_i),
    .enemy_lives_i(enemy_lives_i), .player_box_i(player_box_i),
    .player_bullet_i(player_bullet_i), .enemy_box_i(enemy_box_i),
    .enemy_bullet_i(enemy_bullet_i), .hard_block_i(hard_block_i),
    .destroyable_block_i(destroyable_block_i), .eagle_block_i(eagle_block_i),
    .player_bullet_explode_o(player_bullet_explode_o),
    .enemy_bullet_explode_o(enemy_bullet_explode_o),
    .bullet_collide_wall_o(bullet_collide_wall_o),
    .bullet_collide_eagle_o(bullet_collide_eagle_o),
    .player_die_o(player_die_o), .enemy_die_o(enemy_die_o),
    .player_revive_o(player_revive_o), .enemy_revive_o(enemy_revive_o),
    .player_alive_o(player_alive_o), .enemy_alive_o(enemy_alive_o),
    .player_lives_left_o(player_lives_left_o), .enemies_active_o(enemies_active_o),
    .player_score_o(player_score_o), .game_over_o(game_over_o), .victory_o(victory_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st[NT], m_lv[NT], m_rem[NT], m_score[NP];
  bit m_die[NT], m_rev[NT], m_bprev[NP];
  bit m_go, m_vic, started = 1'b0;

  function automatic int lives_init(int t);
    logic [LW-1:0] v;
    if (t < NP) v = player_lives_i[t*LW +: LW];
    else        v = enemy_lives_i[(t-NP)*LW +: LW];
    return int'(v);
  endfunction

  function automatic bit hit_of(int t);
    if (t < NP) return player_box_i[t] && (enemy_bullet_i != '0);
    return enemy_box_i[t-NP] && (player_bullet_i != '0);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_st[t] = M_IDLE; m_lv[t] = 0; m_rem[t] = 0; m_die[t] = 0; m_rev[t] = 0;
    end
    for (int q = 0; q < NP; q++) begin m_score[q] = 0; m_bprev[q] = 0; end
    m_go = 0; m_vic = 0;
  endtask

  task automatic model_step();
    bit rs, anyb, allp, alle, cur;
    int kills[NP];
    int s;
    rs   = round_start_i;
    anyb = (player_bullet_i != '0) || (enemy_bullet_i != '0);
    for (int q = 0; q < NP; q++) kills[q] = 0;
    for (int e = 0; e < NE; e++)
      if (!rs && m_st[NP+e] == M_LIV && hit_of(NP+e))
        for (int q = 0; q < NP; q++) if (player_bullet_i[q]) kills[q]++;
    for (int q = 0; q < NP; q++) begin
      cur = player_bullet_i[q] && destroyable_block_i;
      s = m_score[q] + kills[q] * KP + ((cur && !m_bprev[q]) ? BP : 0);
      if (score_clear_i) s = 0;
      else if (s > SMAX) s = SMAX;
      m_score[q] = s;
      m_bprev[q] = cur;
    end
    for (int t = 0; t < NT; t++) begin
      m_die[t] = 0; m_rev[t] = 0;
      if (rs) begin
        m_lv[t] = lives_init(t);
        m_st[t] = (m_lv[t] != 0) ? M_LIV : M_OUT;
      end else begin
        case (m_st[t])
          M_LIV: if (hit_of(t)) begin m_st[t] = M_HIT; m_die[t] = 1; end
          M_HIT: begin
            m_lv[t]--;
            if (m_lv[t] >= 1) begin m_st[t] = M_WAIT; m_rem[t] = RC; end
            else m_st[t] = M_OUT;
          end
          M_WAIT: begin
            m_rem[t]--;
            if (m_rem[t] == 0) begin
              m_rev[t] = 1;
`ifdef COMBAT_SHIELD_EN
              m_st[t] = M_SHLD; m_rem[t] = SC;
`else
              m_st[t] = M_LIV;
`endif
            end
          end
          M_SHLD: begin m_rem[t]--; if (m_rem[t] == 0) m_st[t] = M_LIV; end
          default: ;
        endcase
      end
    end
    allp = 1; alle = 1;
    for (int q = 0; q < NP; q++) if (m_st[q] != M_OUT) allp = 0;
    for (int e = 0; e < NE; e++) if (m_st[NP+e] != M_OUT) alle = 0;
    m_go  = (m_go && !rs) || allp || (eagle_block_i && anyb && !rs);
    m_vic = (m_vic && !rs) || (alle && !m_go);
  endtask

  always @(posedge clk) begin
    if (!reset_ni) model_reset();
    else model_step();
    started = 1'b1;
  end

  task automatic compare_all();
    int act_cnt;
    bit pexp, eexp, anyb;
    for (int q = 0; q < NP; q++) begin
      chk("player_alive", q, 64'(player_alive_o[q]), 64'(m_st[q] == M_LIV || m_st[q] == M_SHLD));
      chk("player_die", q, 64'(player_die_o[q]), 64'(m_die[q]));
      chk("player_revive", q, 64'(player_revive_o[q]), 64'(m_rev[q]));
      chk("player_lives", q, 64'(player_lives_left_o[q*LW +: LW]), 64'(m_lv[q]));
      chk("player_score", q, 64'(player_score_o[q*SW +: SW]), 64'(m_score[q]));
    end
    act_cnt = 0;
    for (int e = 0; e < NE; e++) begin
      chk("enemy_alive", e, 64'(enemy_alive_o[e]), 64'(m_st[NP+e] == M_LIV || m_st[NP+e] == M_SHLD));
      chk("enemy_die", e, 64'(enemy_die_o[e]), 64'(m_die[NP+e]));
      chk("enemy_revive", e, 64'(enemy_revive_o[e]), 64'(m_rev[NP+e]));
      if (m_st[NP+e] != M_IDLE && m_st[NP+e] != M_OUT) act_cnt++;
    end
    chk("enemies_active", 0, 64'(enemies_active_o), 64'(act_cnt));
    chk("game_over", 0, 64'(game_over_o), 64'(m_go));
    chk("victory", 0, 64'(victory_o), 64'(m_vic));
    anyb = (player_bullet_i != '0) || (enemy_bullet_i != '0);
    pexp = hard_block_i || (player_box_i != '0) || (enemy_box_i != '0) || (enemy_bullet_i != '0);
    eexp = hard_block_i || (player_box_i != '0) || (enemy_box_i != '0) || (player_bullet_i != '0);
    for (int q = 0; q < NP; q++)
      chk("player_explode", q, 64'(player_bullet_explode_o[q]), 64'(player_bullet_i[q] && pexp));
    for (int e = 0; e < NE; e++)
      chk("enemy_explode", e, 64'(enemy_bullet_explode_o[e]), 64'(enemy_bullet_i[e] && eexp));
    chk("wall", 0, 64'(bullet_collide_wall_o), 64'(destroyable_block_i && anyb));
    chk("eagle", 0, 64'(bullet_collide_eagle_o), 64'(eagle_block_i && anyb));
  endtask

  always @(negedge clk) if (started) compare_all();

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic idle_in();
    player_box_i = '0; player_bullet_i = '0; enemy_box_i = '0; enemy_bullet_i = '0;
    hard_block_i = 0; destroyable_block_i = 0; eagle_block_i = 0;
    round_start_i = 0; score_clear_i = 0;
  endtask

  task automatic start_round(input logic [NP*LW-1:0] pl, input logic [NE*LW-1:0] el);
    player_lives_i = pl; enemy_lives_i = el; round_start_i = 1;
    cyc();
    round_start_i = 0;
  endtask

  function automatic logic [7:0] rbits(input int n, input int den);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = ($urandom_range(0, den - 1) == 0);
    return v;
  endfunction

  localparam logic [NE*LW-1:0] E_ONES = {NE{4'd1}};

  initial begin
    int dies, n;
    bit found;
    logic [7:0] tmp;

    cyc(3);
    chk("lit_reset_active", 0, 64'(enemies_active_o), 64'd0);
    chk("lit_reset_score", 1, 64'(player_score_o[SW +: SW]), 64'd0);
    chk("lit_reset_game_over", 0, 64'(game_over_o), 64'd0);
    reset_ni = 1;
    cyc();

    // single kill credited once despite sustained overlap
    start_round({4'd3, 4'd3}, E_ONES);
    chk("lit_active_start", 0, 64'(enemies_active_o), 64'd4);
    enemy_box_i[0] = 1; player_bullet_i[1] = 1;
    dies = 0;
    repeat (5) begin cyc(); dies += int'(enemy_die_o[0]); end
    idle_in(); cyc(); dies += int'(enemy_die_o[0]);
    chk("lit_kill_die_count", 0, 64'(dies), 64'd1);
    chk("lit_kill_score", 1, 64'(player_score_o[SW +: SW]), 64'd10);
    chk("lit_kill_score", 0, 64'(player_score_o[0 +: SW]), 64'd0);
    chk("lit_kill_active", 0, 64'(enemies_active_o), 64'd3);

    // player death, revive delay, second death, game over
    start_round({4'd1, 4'd2}, E_ONES);
    player_box_i[0] = 1; enemy_bullet_i[2] = 1;
    cyc();
    chk("lit_p0_die", 0, 64'(player_die_o[0]), 64'd1);
    idle_in(); cyc();
    chk("lit_p0_lives", 0, 64'(player_lives_left_o[0 +: LW]), 64'd1);
    n = 1; found = 0;
    while (n < 40 && !found) begin
      cyc(); n++;
      if (player_revive_o[0]) found = 1;
    end
    chk("lit_revive_delay", 0, 64'(n), 64'(RC + 1));
`ifdef COMBAT_SHIELD_EN
    player_box_i[0] = 1; enemy_bullet_i[0] = 1;
    cyc();
    chk("lit_shield_ignores_hit", 0, 64'(player_die_o[0]), 64'd0);
    idle_in(); cyc(SC + 1);
`else
    cyc(2);
`endif
    player_box_i[0] = 1; enemy_bullet_i[1] = 1;
    cyc();
    chk("lit_p0_die2", 0, 64'(player_die_o[0]), 64'd1);
    idle_in(); cyc();
    chk("lit_p0_lives0", 0, 64'(player_lives_left_o[0 +: LW]), 64'd0);
    chk("lit_go_one_out", 0, 64'(game_over_o), 64'd0);
    player_box_i[1] = 1; enemy_bullet_i[3] = 1;
    cyc(); idle_in(); cyc();
    chk("lit_game_over", 0, 64'(game_over_o), 64'd1);

    // eagle hit and round restart during WAIT
    start_round({4'd3, 4'd3}, E_ONES);
    chk("lit_go_cleared", 0, 64'(game_over_o), 64'd0);
    player_box_i[0] = 1; enemy_bullet_i[0] = 1;
    cyc(); idle_in(); cyc();
    eagle_block_i = 1; enemy_bullet_i[1] = 1;
    #1;
    chk("lit_eagle_comb", 0, 64'(bullet_collide_eagle_o), 64'd1);
    cyc(); idle_in();
    chk("lit_eagle_go", 0, 64'(game_over_o), 64'd1);
    cyc(2);
    chk("lit_eagle_sticky", 0, 64'(game_over_o), 64'd1);
    start_round({4'd3, 4'd3}, E_ONES);
    chk("lit_restart_alive", 0, 64'(player_alive_o[0]), 64'd1);
    chk("lit_restart_lives", 0, 64'(player_lives_left_o[0 +: LW]), 64'd3);
    chk("lit_restart_go", 0, 64'(game_over_o), 64'd0);

    // score clear beats a kill; kill + block rise sums
    player_bullet_i[0] = 1; enemy_box_i[1] = 1; score_clear_i = 1;
    cyc(); idle_in();
    chk("lit_clear_vs_kill", 0, 64'(player_score_o[0 +: SW]), 64'd0);
    chk("lit_clear_vs_kill", 1, 64'(player_score_o[SW +: SW]), 64'd0);
    start_round({4'd3, 4'd3}, E_ONES);
    player_bullet_i[0] = 1; enemy_box_i[2] = 1; destroyable_block_i = 1;
    cyc(); idle_in();
    chk("lit_kill_plus_block", 0, 64'(player_score_o[0 +: SW]), 64'd11);

    // saturation
    score_clear_i = 1; cyc(); score_clear_i = 0;
    for (int i = 0; i < 51; i++) begin
      start_round({4'd3, 4'd3}, E_ONES);
      player_bullet_i[0] = 1; enemy_box_i = '1;
      cyc(); idle_in();
    end
    chk("lit_score_2040", 0, 64'(player_score_o[0 +: SW]), 64'd2040);
    start_round({4'd3, 4'd3}, E_ONES);
    player_bullet_i[0] = 1; enemy_box_i[0] = 1; destroyable_block_i = 1;
    cyc(); idle_in();
    chk("lit_score_sat", 0, 64'(player_score_o[0 +: SW]), 64'd2047);

    // zero-life enemies
    start_round({4'd3, 4'd3}, {4'd1, 4'd1, 4'd1, 4'd0});
    chk("lit_zero_life_active", 0, 64'(enemies_active_o), 64'd3);
    chk("lit_zero_life_alive", 0, 64'(enemy_alive_o[0]), 64'd0);
    start_round({4'd3, 4'd3}, '0);
    chk("lit_victory", 0, 64'(victory_o), 64'd1);
    chk("lit_victory_active", 0, 64'(enemies_active_o), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tmp = rbits(NP, 4); player_box_i = tmp[NP-1:0];
      tmp = rbits(NP, 4); player_bullet_i = tmp[NP-1:0];
      tmp = rbits(NE, 4); enemy_box_i = tmp[NE-1:0];
      tmp = rbits(NE, 5); enemy_bullet_i = tmp[NE-1:0];
      hard_block_i        = ($urandom_range(0, 7) == 0);
      destroyable_block_i = ($urandom_range(0, 3) == 0);
      eagle_block_i       = ($urandom_range(0, 59) == 0);
      score_clear_i       = ($urandom_range(0, 149) == 0);
      round_start_i       = (i == 0) || ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NP; k++) player_lives_i[k*LW +: LW] = LW'($urandom_range(0, 3));
      for (int k = 0; k < NE; k++) enemy_lives_i[k*LW +: LW] = LW'($urandom_range(0, 3));
      cyc();
    end
    idle_in();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/combat_resolver.md
# combat_resolver

Parametrised collision, life and score resolver for the tank game: the multi-player, multi-enemy successor of the two-player/one-enemy collision block. It sits between the pixel-level overlap detectors (box, bullet and block hit flags from the renderer) and the game controller. Each tank gets its own life state machine with a revive delay and an optional spawn shield. Kills are credited exactly once, scores saturate, and the block reports round outcome (game over / victory).

## Interface
Parameters:
- NUM_PLAYERS, 2, number of player tanks
- NUM_ENEMIES, 4, number of enemy tanks
- LIVES_W, 4, width of each lives field
- SCORE_W, 11, width of each player score
- REVIVE_CYCLES, 1000000, cycles spent in WAIT before respawn (≥2)
- SHIELD_CYCLES, 250000, invulnerability cycles after respawn (≥1, used only with COMBAT_SHIELD_EN)
- KILL_POINTS, 10, score per enemy kill
- BLOCK_POINTS, 1, score per destroyable-block hit

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- round_start_i  in  1  sync pulse: load lives, all tanks to LIVING
- score_clear_i  in  1  sync pulse: clear all scores
- player_lives_i  in  NUM_PLAYERS*LIVES_W  initial lives, field p at [p*LIVES_W +: LIVES_W]
- enemy_lives_i  in  NUM_ENEMIES*LIVES_W  initial lives per enemy
- player_box_i / player_bullet_i  in  NUM_PLAYERS  current pixel inside tank box / bullet
- enemy_box_i / enemy_bullet_i  in  NUM_ENEMIES  same for enemies
- hard_block_i, destroyable_block_i, eagle_block_i  in  1  pixel inside block class
- player_bullet_explode_o  out  NUM_PLAYERS  combinational explode request
- enemy_bullet_explode_o  out  NUM_ENEMIES  combinational explode request
- bullet_collide_wall_o, bullet_collide_eagle_o  out  1  combinational
- player_die_o / enemy_die_o  out  NUM_*  one-cycle death pulse
- player_revive_o / enemy_revive_o  out  NUM_*  one-cycle respawn pulse
- player_alive_o / enemy_alive_o  out  NUM_*  tank hittable/drawable (LIVING or SHIELD)
- player_lives_left_o  out  NUM_PLAYERS*LIVES_W  remaining lives
- enemies_active_o  out  $clog2(NUM_ENEMIES+1)  enemies not in OUT/IDLE
- player_score_o  out  NUM_PLAYERS*SCORE_W  scores
- game_over_o, victory_o  out  1  round outcome, sticky

## Operation
- Explode outputs, per bullet b: b && (hard_block_i || any player box || any enemy box || any opposing bullet). wall_o = destroyable_block_i && any bullet; eagle_o = eagle_block_i && any bullet.
- Per-tank FSM: IDLE, LIVING, HIT, WAIT, SHIELD, OUT.
- IDLE → LIVING on round_start_i when loaded lives ≠ 0, otherwise IDLE → OUT.
- LIVING → HIT when own box && any opposing bullet (players are hit by enemy bullets, enemies by player bullets).
- HIT lasts one cycle: lives ← lives−1. Next state is WAIT if the result is ≥1, otherwise OUT. die_o is high for the HIT cycle.
- WAIT: the counter clears on entry. After REVIVE_CYCLES cycles the tank goes to SHIELD (or LIVING), and revive_o is high for the first cycle of that state.
- SHIELD: hits are ignored. After SHIELD_CYCLES cycles → LIVING.
- OUT is terminal until round_start_i.
- Kill credit: on the cycle an enemy makes LIVING→HIT, every player p with player_bullet_i[p] set gains KILL_POINTS. Only one credit per kill; continued overlap adds nothing.
- Block credit: BLOCK_POINTS on the rising edge of (player_bullet_i[p] && destroyable_block_i), using a registered previous value.
- Kill and block credit in the same cycle are summed. The score saturates at 2^SCORE_W−1.
- game_over_o sets when every player is OUT or on eagle_block_i && any bullet. victory_o sets when every enemy is OUT and game_over_o is clear. Both hold until round_start_i.

## Timing
- Reset: all FSMs IDLE; lives, scores and counters 0. All registered outputs are 0, and enemies_active_o = 0.
- Collision flags are sampled on a rising edge. The HIT state and die_o appear the next cycle. lives_left_o updates the cycle after HIT.
- Score updates one cycle after the qualifying sample.
- round_start_i has priority over all FSM activity, including mid-WAIT, mid-SHIELD and same-cycle hits. It also clears game_over_o and victory_o, but it does not touch scores.
- score_clear_i beats a same-cycle score event: the result is 0.
- enemies_active_o and game_over_o/victory_o are registered from next-state values, so they agree with the state in the same cycle.

## Configuration
- COMBAT_SHIELD_EN defined: the SHIELD state exists, alive_o is high during SHIELD, and hits are ignored there.
- COMBAT_SHIELD_EN undefined: WAIT → LIVING directly, and revive_o fires on LIVING entry. SHIELD_CYCLES is unused and no shield counter is built.

## Test plan
- Start a round with player lives 3 and enemy lives 1; hold enemy_box_i[0] with player_bullet_i[1] for 5 cycles → enemy_die_o[0] pulses once, player 1 score = 10, enemies_active_o drops by 1.
- Player 0 (lives 2) hit by an enemy bullet → die pulse, lives 1, revive_o after REVIVE_CYCLES. With the shield, a hit during SHIELD is ignored. A second hit while LIVING → OUT, and game_over_o once player 1 is also OUT.
- Same cycle: player 0 kills an enemy and its bullet rises on destroyable_block_i → score +11. Preload the score to 2040 → saturates at 2047.
- score_clear_i together with a kill → score 0. round_start_i during WAIT → LIVING, lives reloaded, game flags cleared.
- eagle_block_i with any bullet → eagle_o combinational, game_over_o the next cycle, and it stays set.
- Enemy lives 0 at round_start_i → that enemy is OUT immediately. All enemies 0 → victory_o the cycle after the start.
